// File: rtl/dvbc_pkg.sv
// rtl/dvbc_pkg.sv - shared DVB-C (de)interleaver constants and branch segment layout
package dvbc_pkg;

  localparam int         DVBC_I             = 12;
  localparam int         DVBC_M             = 17;
  localparam int         DVBC_PKT_LEN       = 204;
  localparam logic [7:0] DVBC_SYNC_BYTE     = 8'h47;
  localparam logic [7:0] DVBC_SYNC_BYTE_INV = 8'hB8;

  // Segments are packed longest first: base_j = M * sum_{k<j} (I-1-k)
  function automatic int branch_base(input int j, input int i = DVBC_I, input int m = DVBC_M);
    return m * (j * (i - 1) - (j * (j - 1)) / 2);
  endfunction

  function automatic int branch_len(input int j, input int i = DVBC_I, input int m = DVBC_M);
    return (i - 1 - j) * m;
  endfunction

endpackage

// File: rtl/dvbc_sp_ram.sv
// rtl/dvbc_sp_ram.sv - single-port read-first RAM with registered read data
module dvbc_sp_ram #(
  parameter int DEPTH = 1122,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (en) rdata_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    if (en) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dvbc_deinterleaver.sv
// rtl/dvbc_deinterleaver.sv - Forney convolutional byte deinterleaver (I=12, M=17)
module dvbc_deinterleaver
  import dvbc_pkg::*;
#(
  parameter int I       = DVBC_I,
  parameter int M       = DVBC_M,
  parameter int PKT_LEN = DVBC_PKT_LEN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_sync,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_sync,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       sync_err
);

  localparam int DEPTH = M * I * (I - 1) / 2;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = $clog2(I);
  localparam int PTRW  = $clog2((I - 1) * M);
  localparam int PCW   = $clog2(PKT_LEN);
  localparam int TOTAL = I * (I - 1) * M;
  localparam int QW    = $clog2(TOTAL + 1);
  localparam int NSEG  = I - 1;

  logic [BW-1:0]   br_q, br_d, br_eff;
  logic [PCW-1:0]  pc_q, pc_d, pc_eff;
  logic [QW-1:0]   prime_q, prime_d, prime_eff;
  logic [PTRW-1:0] ptr_q [NSEG];
  logic [PTRW-1:0] ptr_d [NSEG];
  logic            out_valid_q, out_valid_d;
  logic            out_sync_q, out_sync_d;
  logic            sync_err_q, sync_err_d;
  logic            byp_sel_q, byp_sel_d;
  logic [7:0]      byp_data_q, byp_data_d;
  logic            accept, sync_acc, resync, bypass, ram_en;
  logic [AW-1:0]   ram_addr;
  logic [7:0]      ram_rdata;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign sync_acc  = accept && in_sync;
  assign resync    = sync_acc && (br_q != '0);
  assign br_eff    = sync_acc ? '0 : br_q;
  assign pc_eff    = sync_acc ? '0 : pc_q;
  assign prime_eff = resync ? '0 : prime_q;
  assign bypass    = (br_eff == BW'(I - 1));
  assign ram_en    = accept && !bypass;

  always_comb begin
    br_d        = br_q;
    pc_d        = pc_q;
    prime_d     = prime_q;
    ptr_d       = ptr_q;
    ram_addr    = '0;
    out_valid_d = out_valid_q;
    out_sync_d  = out_sync_q;
    sync_err_d  = 1'b0;
    byp_sel_d   = byp_sel_q;
    byp_data_d  = byp_data_q;
    for (int j = 0; j < NSEG; j++) begin
      if (br_eff == BW'(j)) ram_addr = AW'(branch_base(j, I, M)) + AW'(ptr_q[j]);
    end
    if (accept) begin
      br_d    = bypass ? '0 : br_eff + 1'b1;
      pc_d    = (pc_eff == PCW'(PKT_LEN - 1)) ? '0 : pc_eff + 1'b1;
      prime_d = (prime_eff == QW'(TOTAL)) ? prime_eff : prime_eff + 1'b1;
      for (int j = 0; j < NSEG; j++) begin
        if (br_eff == BW'(j))
          ptr_d[j] = (ptr_q[j] == PTRW'(branch_len(j, I, M) - 1)) ? '0 : ptr_q[j] + 1'b1;
      end
      // Until every segment has been refilled, RAM reads are stale and dropped
      out_valid_d = (prime_eff == QW'(TOTAL));
      out_sync_d  = (pc_eff == '0);
      sync_err_d  = resync;
      byp_sel_d   = bypass;
      byp_data_d  = in_data;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_q        <= '0;
      pc_q        <= '0;
      prime_q     <= '0;
      for (int j = 0; j < NSEG; j++) ptr_q[j] <= '0;
      out_valid_q <= 1'b0;
      out_sync_q  <= 1'b0;
      sync_err_q  <= 1'b0;
      byp_sel_q   <= 1'b0;
      byp_data_q  <= '0;
    end else begin
      br_q        <= br_d;
      pc_q        <= pc_d;
      prime_q     <= prime_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_sync_q  <= out_sync_d;
      sync_err_q  <= sync_err_d;
      byp_sel_q   <= byp_sel_d;
      byp_data_q  <= byp_data_d;
    end
  end

  dvbc_sp_ram #(
    .DEPTH (DEPTH),
    .WIDTH (8),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ram_en),
    .addr  (ram_addr),
    .wdata (in_data),
    .rdata (ram_rdata)
  );

  assign out_data  = byp_sel_q ? byp_data_q : ram_rdata;
  assign out_sync  = out_sync_q;
  assign out_valid = out_valid_q;
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_dvbc_deinterleaver.sv
// tb/tb_dvbc_deinterleaver.sv - scoreboard bench: interleaver model feeding the deinterleaver
module tb_dvbc_deinterleaver;

  localparam int I     = 12;
  localparam int M     = 17;
  localparam int PKT   = 204;
  localparam int TOTAL = 2244;

  logic       clk, rst_n;
  logic [7:0] in_data;
  logic       in_sync, in_valid, in_ready;
  logic [7:0] out_data;
  logic       out_sync, out_valid, out_ready, sync_err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [8:0] exp_q [$];
  logic [7:0] il_mem [I][187];
  int         il_idx [I];
  int         pos;
  int         acc_cnt, n_valid, n_sync_err;
  logic       first_seen, hold_chk, mon_en, bp_en, resync_flag;
  logic [7:0] prev_data;
  logic       prev_sync;

  dvbc_deinterleaver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sync   (in_sync),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sync  (out_sync),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sync_err  (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && mon_en) begin
      if (hold_chk) begin
        n_assert++;
        if (out_valid !== 1'b1 || out_data !== prev_data || out_sync !== prev_sync) begin
          n_fail++;
          $display("FAIL stall_hold: got valid=%b data=%h sync=%b, need valid=1 data=%h sync=%b",
                   out_valid, out_data, out_sync, prev_data, prev_sync);
        end
      end
      n_assert++;
      if (out_valid === 1'b1 && acc_cnt < TOTAL + 1) begin
        n_fail++;
        $display("FAIL priming_silent: out_valid=1 after %0d accepted bytes, need 0 until %0d", acc_cnt, TOTAL + 1);
      end
      if (!first_seen && acc_cnt == TOTAL + 1) begin
        first_seen = 1'b1;
        n_assert++;
        if (out_valid !== 1'b1 || out_data !== 8'h47 || out_sync !== 1'b1) begin
          n_fail++;
          $display("FAIL first_output: got valid=%b data=%h sync=%b, need 1/47/1", out_valid, out_data, out_sync);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_valid++;
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: data=%h with empty scoreboard", out_data);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          if ({out_sync, out_data} !== e) begin
            n_fail++;
            $display("FAIL out_byte: got sync=%b data=%h, need sync=%b data=%h", out_sync, out_data, e[8], e[7:0]);
          end
        end
      end
      if (sync_err === 1'b1) n_sync_err++;
      hold_chk  = (out_valid === 1'b1) && (out_ready === 1'b0);
      prev_data = out_data;
      prev_sync = out_sync;
      if (in_valid && in_ready) acc_cnt = (in_sync && resync_flag) ? 1 : acc_cnt + 1;
    end
  end

  task automatic reset_model();
    pos = 0;
    for (int b = 0; b < I; b++) begin
      il_idx[b] = 0;
      for (int k = 0; k < 187; k++) il_mem[b][k] = 8'h00;
    end
  endtask

  task automatic clear_bench();
    exp_q.delete();
    acc_cnt    = 0;
    n_valid    = 0;
    n_sync_err = 0;
    first_seen = 1'b0;
    hold_chk   = 1'b0;
    reset_model();
  endtask

  task automatic send(input logic [7:0] d, input logic s);
    int n;
    n = 0;
    in_data  = d;
    in_sync  = s;
    in_valid = 1'b1;
    forever begin
      if (bp_en) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        n_assert++;
        n_fail++;
        $display("FAIL send_timeout: in_ready stuck at %b", in_ready);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sync  = 1'b0;
  endtask

  task automatic feed_one();
    logic [7:0] src, il;
    int p, k, b;
    p   = pos / PKT;
    k   = pos % PKT;
    src = (k == 0) ? 8'h47 : 8'(p + k);
    exp_q.push_back({k == 0, src});
    b = pos % I;
    if (b == 0) il = src;
    else begin
      il = il_mem[b][il_idx[b]];
      il_mem[b][il_idx[b]] = src;
      il_idx[b] = (il_idx[b] + 1) % (b * M);
    end
    send(il, k == 0);
    pos++;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    clear_bench();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bp_en     = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_tail(input string name, input int exp_valid, input int exp_err);
    n_assert++;
    if (exp_q.size() != TOTAL) begin
      n_fail++;
      $display("FAIL %s_in_flight: got %0d pending, need %0d", name, exp_q.size(), TOTAL);
    end
    n_assert++;
    if (n_valid != exp_valid) begin
      n_fail++;
      $display("FAIL %s_out_count: got %0d outputs, need %0d", name, n_valid, exp_valid);
    end
    n_assert++;
    if (n_sync_err != exp_err) begin
      n_fail++;
      $display("FAIL %s_sync_err: got %0d pulses, need %0d", name, n_sync_err, exp_err);
    end
    n_assert++;
    if (!first_seen) begin
      n_fail++;
      $display("FAIL %s_first_seen: got 0, need 1", name);
    end
  endtask

  task automatic check_idle(input string name);
    n_assert++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sync !== 1'b0 || sync_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_outputs: got valid=%b data=%h sync=%b err=%b, need all 0",
               name, out_valid, out_data, out_sync, sync_err);
    end
    n_assert++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_in_ready: got %b, need 1", name, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset_held");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset_released");
  endtask

  task automatic test_loopback();
    do_reset();
    mon_en    = 1'b1;
    out_ready = 1'b1;
    repeat (20 * PKT) feed_one();
    drain();
    check_tail("loopback", 20 * PKT - TOTAL, 0);
  endtask

  task automatic test_backpressure();
    do_reset();
    bp_en = 1'b1;
    repeat (14 * PKT) feed_one();
    drain();
    check_tail("backpressure", 14 * PKT - TOTAL, 0);
  endtask

  task automatic test_misaligned_sync();
    n_sync_err = 0;
    for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    n_assert++;
    if (n_sync_err != 0) begin
      n_fail++;
      $display("FAIL junk_sync_err: got %0d pulses, need 0", n_sync_err);
    end
    exp_q.delete();
    reset_model();
    n_valid    = 0;
    first_seen = 1'b0;
    resync_flag = 1'b1;
    feed_one();
    resync_flag = 1'b0;
    repeat (13 * PKT - 1) feed_one();
    drain();
    check_tail("misaligned", 13 * PKT - TOTAL, 1);
  endtask

  task automatic test_async_reset();
    logic [8:0] pend;
    repeat (50) feed_one();
    feed_one();
    out_ready = 1'b0;
    @(negedge clk);
    pend = exp_q[0];
    n_assert++;
    if (out_valid !== 1'b1 || out_data !== pend[7:0]) begin
      n_fail++;
      $display("FAIL pre_reset_output: got valid=%b data=%h, need 1/%h", out_valid, out_data, pend[7:0]);
    end
    #2 rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    @(negedge clk);
    clear_bench();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    repeat (12 * PKT) feed_one();
    drain();
    check_tail("after_reset", 12 * PKT - TOTAL, 0);
  endtask

  initial begin
    in_data     = 8'h00;
    in_sync     = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    rst_n       = 1'b0;
    bp_en       = 1'b0;
    mon_en      = 1'b0;
    resync_flag = 1'b0;
    prev_data   = 8'h00;
    prev_sync   = 1'b0;
    clear_bench();
    test_reset();
    test_loopback();
    test_backpressure();
    test_misaligned_sync();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dvbc_deinterleaver.md
# dvbc_deinterleaver

Convolutional (Forney) byte deinterleaver for the DVB-C receive path, per EN 300 429 (I = 12 branches, M = 17 bytes per delay unit). It undoes the transmit interleaver: branch j delays by (I-1-j)·M branch visits, so every byte sees the same total delay of I·(I-1)·M = 2244 bytes. It sits between frame sync detection and the RS(204,188) decoder, moving bytes in and out over valid/ready streams.

## Interface

Parameters:
- I, 12, number of commutator branches.
- M, 17, delay unit in bytes.
- PKT_LEN, 204, packet length in bytes; must equal I·M.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  8  interleaved byte.
- in_sync  in  1  marks the first byte of a packet (the sync byte). Qualified by in_valid.
- in_valid  in  1  input byte valid.
- in_ready  out  1  input accepted when in_valid && in_ready.
- out_data  out  8  deinterleaved byte.
- out_sync  out  1  marks the first byte of a deinterleaved packet.
- out_valid  out  1  output byte valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- sync_err  out  1  one-cycle pulse when in_sync arrives with the commutator not at branch 0.

## Operation

- Commutator: branch counter br, 0..I-1. It advances by one, wrapping, on each accepted byte.
- Storage: one RAM of depth M·I·(I-1)/2 = 1122 bytes and 11-bit address.
  - Branch j < I-1 owns a circular segment of length L_j = (I-1-j)·M, starting at base_j = M·Σ_{k<j}(I-1-k).
  - Each such branch has its own pointer ptr_j, 8 bits, range 0..L_j-1.
- On acceptance at branch j < I-1:
  - Read-first at base_j + ptr_j: the old byte goes to the output and in_data is written in its place.
  - ptr_j then increments, wrapping L_j-1 → 0.
- Branch I-1 has zero delay: in_data bypasses the RAM into the output register.
- Sync alignment: in_sync accepted while br ≠ 0 forces br to 0 for that byte and pulses sync_err.
  - Resync does not touch the pointers or the RAM.
  - The realigned byte is processed as branch 0.
- Byte counter pc, 0..PKT_LEN-1:
  - Counts accepted bytes and wraps.
  - Forced to 0 on an accepted in_sync, then advances from there.
- Priming:
  - Counter prime counts accepted bytes up to 2244, then saturates.
  - While prime < 2244, bytes are accepted and stored, but their outputs are discarded (out_valid stays 0). This hides the undefined RAM contents.
  - A resync with sync_err restarts prime at 0.
- out_sync = 1 on an output whose input byte had pc == 0. Because 2244 = 11·204, this coincides with the true deinterleaved sync byte.

## Timing

- Reset values: out_data = 0, out_sync = 0, out_valid = 0, sync_err = 0, br = 0, all ptr_j = 0, pc = 0, prime = 0. The RAM is not cleared.
- Latency: an accepted byte at cycle t produces its output (the byte read, or the bypass byte) on out_data at t+1.
  - The RAM read is registered and is the output register.
  - The bypass path is muxed into the same register stage.
- Flow control: in_ready = !out_valid || out_ready. This is combinational; there is no skid buffer.
- Stall: while out_valid && !out_ready, out_data, out_sync and out_valid hold. The RAM enable and all counters are gated by acceptance.
- Simultaneous accept-in and accept-out in one cycle gives a full-throughput stream of one byte per cycle.
- Reset mid-stream: all state returns to reset values immediately and priming restarts.

## Structure

- A shared package dvbc_pkg holds:
  - DVBC_I = 12, DVBC_M = 17, DVBC_PKT_LEN = 204, DVBC_SYNC_BYTE = 8'h47, DVBC_SYNC_BYTE_INV = 8'hB8.
  - A function branch_base(j).
  - The same constants will be used by the interleaver.
- Sub-module dvbc_sp_ram: single-port, read-first, registered-read RAM with enable, parameterised by depth and width.
- The branch pointers and the base/length lookup stay in dvbc_deinterleaver.

## Test plan

- Loopback: dvbc_interleaver → dvbc_deinterleaver with 20 packets of 0x47 followed by 203 incrementing bytes. The deinterleaver output must match the input delayed by exactly 2244 bytes, with out_sync on every 0x47 and no sync_err.
- Priming: after reset, stream 2244 bytes. out_valid must stay 0 throughout; the first out_valid follows byte 2245 and carries the first byte of packet 0.
- Backpressure: toggle out_ready randomly at 50% duty. Data order must be identical to the free-running run; out_data must hold during stalls; no bytes may be dropped or duplicated.
- Misaligned sync: inject in_sync when br = 5. sync_err must pulse once; br must jump to 0; out_valid must drop for 2244 accepted bytes and then resume aligned.
- Pointer wrap: run 4 packets at full rate on a hand-built interleaved pattern. The branch 0 pointer must wrap at 187 and branch 10 at 17, with outputs correct across each wrap boundary.
- Async reset: assert rst_n low mid-packet, then release. All outputs read 0 in the same cycle, and after 2244 bytes the loopback output is correct again.
